// File: rtl/fetch_stage_if.sv
// Fetch-stage bus bundle: hazard/redirect control from later stages, the
// instruction BRAM read port, and the IF/ID register presented to decode.
//   master : fetch_stage side (drives imem_addr/imem_en and the ifid_* outputs)
//   slave  : environment side (drives stall, redirect_* and imem_dout)
interface fetch_stage_if #(
  parameter int unsigned PC_W    = 9,
  parameter int unsigned INSTR_W = 32
);
  logic               stall;
  logic               redirect_valid;
  logic [PC_W-1:0]    redirect_target;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_en;
  logic [INSTR_W-1:0] imem_dout;
  logic [INSTR_W-1:0] ifid_instr;
  logic [PC_W-1:0]    ifid_pc;
  logic               ifid_valid;

  modport master (
    input  stall, redirect_valid, redirect_target, imem_dout,
    output imem_addr, imem_en, ifid_instr, ifid_pc, ifid_valid
  );

  modport slave (
    output stall, redirect_valid, redirect_target, imem_dout,
    input  imem_addr, imem_en, ifid_instr, ifid_pc, ifid_valid
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage plus IF/ID pipeline register.
// Owns the word PC, drives a synchronous BRAM with 1-cycle read latency, and
// keeps a 1-entry skid buffer so a stall never causes a refetch. EX redirects
// squash everything younger and restart fetch at the target.
// Ports:
//   clk    : rising-edge clock
//   reset  : synchronous, active-high
//   bus    : fetch_stage_if.master (stall, redirect_*, imem_*, ifid_*)
module fetch_stage #(
  parameter int unsigned           PC_W     = 9,
  parameter int unsigned           INSTR_W  = 32,
  parameter logic [PC_W-1:0]       RESET_PC = '0,
  parameter logic [INSTR_W-1:0]    BUBBLE   = 32'h01C0_0000
) (
  input logic            clk,
  input logic            reset,
  fetch_stage_if.master  bus
);

  logic [PC_W-1:0]    pc_q, pc_d;
  logic               inflight_v_q, inflight_v_d;
  logic [PC_W-1:0]    inflight_pc_q, inflight_pc_d;
  logic               skid_v_q, skid_v_d;
  logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
  logic [PC_W-1:0]    skid_pc_q, skid_pc_d;
  logic               ifid_valid_q, ifid_valid_d;
  logic [INSTR_W-1:0] ifid_instr_q, ifid_instr_d;
  logic [PC_W-1:0]    ifid_pc_q, ifid_pc_d;

  // A redirect fetches its target in the same cycle, even while stalled.
  assign bus.imem_addr  = bus.redirect_valid ? bus.redirect_target : pc_q;
  assign bus.imem_en    = !reset && (bus.redirect_valid || !bus.stall);
  assign bus.ifid_instr = ifid_instr_q;
  assign bus.ifid_pc    = ifid_pc_q;
  assign bus.ifid_valid = ifid_valid_q;

  always_comb begin
    pc_d          = pc_q;
    inflight_v_d  = inflight_v_q;
    inflight_pc_d = inflight_pc_q;
    skid_v_d      = skid_v_q;
    skid_instr_d  = skid_instr_q;
    skid_pc_d     = skid_pc_q;
    ifid_valid_d  = ifid_valid_q;
    ifid_instr_d  = ifid_instr_q;
    ifid_pc_d     = ifid_pc_q;

    if (bus.redirect_valid) begin
      // Squash wrong-path words; ifid_pc is left as-is while the bubble passes.
      skid_v_d      = 1'b0;
      ifid_valid_d  = 1'b0;
      ifid_instr_d  = BUBBLE;
      inflight_v_d  = 1'b1;
      inflight_pc_d = bus.redirect_target;
      pc_d          = bus.redirect_target + PC_W'(1);
    end else if (bus.stall) begin
      // No fetch while stalled, so the word already in flight is the only one
      // that can land; park it in the skid.
      inflight_v_d = 1'b0;
      if (inflight_v_q) begin
        skid_v_d     = 1'b1;
        skid_instr_d = bus.imem_dout;
        skid_pc_d    = inflight_pc_q;
      end
    end else begin
      inflight_v_d  = 1'b1;
      inflight_pc_d = pc_q;
      pc_d          = pc_q + PC_W'(1);
      if (skid_v_q) begin
        // Skid is older than anything in flight (inflight was cleared by the stall).
        skid_v_d     = 1'b0;
        ifid_valid_d = 1'b1;
        ifid_instr_d = skid_instr_q;
        ifid_pc_d    = skid_pc_q;
      end else if (inflight_v_q) begin
        ifid_valid_d = 1'b1;
        ifid_instr_d = bus.imem_dout;
        ifid_pc_d    = inflight_pc_q;
      end else begin
        ifid_valid_d = 1'b0;
        ifid_instr_d = BUBBLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      inflight_v_q  <= 1'b0;
      inflight_pc_q <= '0;
      skid_v_q      <= 1'b0;
      skid_instr_q  <= BUBBLE;
      skid_pc_q     <= '0;
      ifid_valid_q  <= 1'b0;
      ifid_instr_q  <= BUBBLE;
      ifid_pc_q     <= '0;
    end else begin
      pc_q          <= pc_d;
      inflight_v_q  <= inflight_v_d;
      inflight_pc_q <= inflight_pc_d;
      skid_v_q      <= skid_v_d;
      skid_instr_q  <= skid_instr_d;
      skid_pc_q     <= skid_pc_d;
      ifid_valid_q  <= ifid_valid_d;
      ifid_instr_q  <= ifid_instr_d;
      ifid_pc_q     <= ifid_pc_d;
    end
  end

endmodule
